// File: rtl/collector_spi_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | collector_spi_slave                                                      |
// | Mode-0 SPI slave endpoint with a Wishbone register interface; oversampled |
// | SCLK/CS_N/MOSI. COLLECTOR_SPI_SLAVE_RXFIFO_EN selects a 4-deep RX FIFO.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module collector_spi_slave (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_miso,
    input  logic [4:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack
);

    localparam logic [2:0] c_adr_rxdata = 3'd0;
    localparam logic [2:0] c_adr_txdata = 3'd1;
    localparam logic [2:0] c_adr_status = 3'd2;

    logic       r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic       r_cs_meta, r_cs_sync, r_cs_d;
    logic       r_mosi_meta, r_mosi_sync;
    logic       r_armed;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_tx_data;
    logic       r_tx_full;
    logic       r_overrun;
    logic       r_ack;
    logic [31:0] r_rdt;

    logic       w_cs_active, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
    logic       w_access, w_wr, w_rd, w_pop, w_push, w_tx_load;
    logic       w_rx_valid, w_overrun_set;
    logic [2:0] w_sel;
    logic [7:0] w_push_byte, w_rx_head;
    logic [31:0] w_rd_data;
    logic       w_unused;

    // cs sync flops reset to "selected" so a frame already in progress at
    // reset release is ignored until CS_N has been seen high (r_armed).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_cs_meta   <= 1'b0;
            r_cs_sync   <= 1'b0;
            r_cs_d      <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_cs_meta   <= i_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_d      <= r_cs_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
            if (r_cs_sync) r_armed <= 1'b1;
        end
    end

    assign w_cs_active = r_armed & ~r_cs_sync;
    assign w_cs_fall   = r_armed & r_cs_d & ~r_cs_sync;
    assign w_cs_rise   = ~r_cs_d & r_cs_sync;
    assign w_sclk_rise = w_cs_active & r_sclk_sync & ~r_sclk_d;
    assign w_sclk_fall = w_cs_active & ~r_sclk_sync & r_sclk_d;

    assign w_push      = w_sclk_rise & (r_bit_cnt == 3'd7);
    assign w_push_byte = {r_rx_shift[6:0], r_mosi_sync};
    assign w_tx_load   = w_cs_fall | (w_sclk_fall & (r_bit_cnt == 3'd0));

    assign w_access = i_wb_stb & ~r_ack;
    assign w_wr     = w_access & i_wb_we;
    assign w_rd     = w_access & ~i_wb_we;
    assign w_sel    = i_wb_adr[4:2];
    assign w_pop    = w_rd & (w_sel == c_adr_rxdata) & w_rx_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
        end else if (w_cs_rise) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
        end else begin
            if (w_cs_fall) r_bit_cnt <= 3'd0;
            if (w_sclk_rise) begin
                r_rx_shift <= w_push_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
            if (w_tx_load)
                r_tx_shift <= r_tx_full ? r_tx_data : 8'h00;
            else if (w_sclk_fall)
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
    end

    // A CPU write on the load cycle wins the full flag; the load saw the old byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_data <= 8'h00;
            r_tx_full <= 1'b0;
        end else if (w_wr && (w_sel == c_adr_txdata)) begin
            r_tx_data <= i_wb_dat[7:0];
            r_tx_full <= 1'b1;
        end else if (w_tx_load) begin
            r_tx_full <= 1'b0;
        end
    end

`ifdef COLLECTOR_SPI_SLAVE_RXFIFO_EN
    logic [7:0] r_fifo [0:3];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_count;
    logic       w_rx_full, w_push_ok;

    assign w_rx_valid    = (r_count != 3'd0);
    assign w_rx_full     = (r_count == 3'd4);
    assign w_rx_head     = r_fifo[r_rd_ptr];
    assign w_push_ok     = w_push & (~w_rx_full | w_pop);
    assign w_overrun_set = w_push & w_rx_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_fifo[r_wr_ptr] <= w_push_byte;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [7:0] r_rx_hold;
    logic       r_rx_valid;

    assign w_rx_valid    = r_rx_valid;
    assign w_rx_head     = r_rx_hold;
    // The holding register keeps the newest byte; the unread one is lost.
    assign w_overrun_set = w_push & r_rx_valid & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_hold  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else if (w_push) begin
            r_rx_hold  <= w_push_byte;
            r_rx_valid <= 1'b1;
        end else if (w_pop) begin
            r_rx_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_overrun <= 1'b0;
        else if (w_overrun_set)
            r_overrun <= 1'b1;
        else if (w_wr && (w_sel == c_adr_status) && i_wb_dat[1])
            r_overrun <= 1'b0;
    end

    always_comb begin
        w_rd_data = 32'h0;
        case (w_sel)
            c_adr_rxdata: w_rd_data = {24'h0, w_rx_valid ? w_rx_head : 8'h00};
            c_adr_txdata: w_rd_data = {24'h0, r_tx_data};
            c_adr_status: w_rd_data = {28'h0, w_cs_active, ~r_tx_full, r_overrun, w_rx_valid};
            default:      w_rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack <= 1'b0;
            r_rdt <= 32'h0;
        end else begin
            r_ack <= w_access;
            r_rdt <= w_rd ? w_rd_data : 32'h0;
        end
    end

    assign o_wb_ack = r_ack;
    assign o_wb_rdt = r_rdt;
    assign o_miso   = r_tx_shift[7] & w_cs_active;

    assign w_unused = &{1'b0, i_wb_adr[1:0], i_wb_dat[31:8]};

endmodule
`default_nettype wire
